mips_decode_stage: RTL and testbench

Instruction-decode (ID) pipeline stage that sits directly upstream of register_file_mips. It accepts instructions from fetch with a valid/ready handshake and drives the register file's two read channels. It collects the operands, which arrive one cycle after the address because the register file's read data is registered. It then presents a decoded, registered bundle to execute with a valid/ready handshake, and handles load-use stalls and branch flushes.

---
 rtl/mips_isa_pkg.sv | 50 +++++
 rtl/mips_instr_decoder.sv | 102 ++++++++++
 rtl/mips_decode_stage.sv | 181 ++++++++++++++++++
 tb/tb_mips_decode_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_isa_pkg                                                          |
// | MIPS subset encodings, ALU op codes, ID-stage states, decode bundle.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;
  localparam logic [3:0] ALU_NOP = 4'd15;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  typedef struct packed {
    logic        reads_rs;
    logic        reads_rt;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        wb_en;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        illegal;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/mips_instr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_instr_decoder                                                    |
// | Combinational MIPS subset decoder: sources, dest, immediate, control. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mips_instr_decoder
  import mips_isa_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output dec_t        dec_o
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  dec_t        w_dec;

  assign w_opcode = instr_i[31:26];
  assign w_funct  = instr_i[5:0];
  assign w_sext   = {{16{instr_i[15]}}, instr_i[15:0]};
  assign w_zext   = {16'h0000, instr_i[15:0]};
  assign rs_o     = instr_i[25:21];
  assign rt_o     = instr_i[20:16];

  always_comb begin
    w_dec        = '0;
    w_dec.alu_op = ALU_NOP;
    case (w_opcode)
      OP_RTYPE: begin
        w_dec.reads_rs = 1'b1;
        w_dec.reads_rt = 1'b1;
        w_dec.dest     = instr_i[15:11];
        w_dec.wb_en    = 1'b1;
        case (w_funct)
          FN_ADD:  w_dec.alu_op = ALU_ADD;
          FN_SUB:  w_dec.alu_op = ALU_SUB;
          FN_AND:  w_dec.alu_op = ALU_AND;
          FN_OR:   w_dec.alu_op = ALU_OR;
          FN_SLT:  w_dec.alu_op = ALU_SLT;
          default: begin
            w_dec         = '0;
            w_dec.alu_op  = ALU_NOP;
            w_dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        w_dec.reads_rs = 1'b1;
        w_dec.imm      = w_sext;
        w_dec.dest     = instr_i[20:16];
        w_dec.alu_op   = ALU_ADD;
        w_dec.wb_en    = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        w_dec.reads_rs = 1'b1;
        w_dec.imm      = w_zext;
        w_dec.dest     = instr_i[20:16];
        w_dec.alu_op   = (w_opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        w_dec.wb_en    = 1'b1;
      end
      OP_LUI: begin
        w_dec.imm    = {instr_i[15:0], 16'h0000};
        w_dec.dest   = instr_i[20:16];
        w_dec.alu_op = ALU_LUI;
        w_dec.wb_en  = 1'b1;
      end
      OP_LW: begin
        w_dec.reads_rs = 1'b1;
        w_dec.imm      = w_sext;
        w_dec.dest     = instr_i[20:16];
        w_dec.alu_op   = ALU_ADD;
        w_dec.mem_rd   = 1'b1;
        w_dec.wb_en    = 1'b1;
      end
      OP_SW: begin
        w_dec.reads_rs = 1'b1;
        w_dec.reads_rt = 1'b1;
        w_dec.imm      = w_sext;
        w_dec.alu_op   = ALU_ADD;
        w_dec.mem_wr   = 1'b1;
      end
      OP_BEQ: begin
        w_dec.reads_rs = 1'b1;
        w_dec.reads_rt = 1'b1;
        w_dec.imm      = w_sext;
        w_dec.alu_op   = ALU_SUB;
        w_dec.branch   = 1'b1;
      end
      default: w_dec.illegal = 1'b1;
    endcase
    // Writes to $zero are architecturally discarded.
    if (w_dec.dest == 5'd0) w_dec.wb_en = 1'b0;
  end

  assign dec_o = w_dec;

endmodule
`default_nettype wire

// File: rtl/mips_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_decode_stage                                                     |
// | ID stage: fetch handshake, RF read issue, load-use stall, EX bundle.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mips_decode_stage
  import mips_isa_pkg::*;
#(
  parameter int n_bit = 31,
  parameter int n_reg = 5
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  output logic             if_ready,
  output logic             rf_r_1_en,
  output logic [n_reg:0]   rf_addr_r_1,
  output logic             rf_r_2_en,
  output logic [n_reg:0]   rf_addr_r_2,
  input  logic [n_bit:0]   rf_r_data_1,
  input  logic [n_bit:0]   rf_r_data_2,
  input  logic             flush,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [3:0]       ex_alu_op,
  output logic [n_bit:0]   ex_rs_data,
  output logic [n_bit:0]   ex_rt_data,
  output logic [31:0]      ex_imm,
  output logic [n_reg:0]   ex_dest,
  output logic             ex_wb_en,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic             ex_branch,
  output logic             ex_illegal,
  output logic [31:0]      ex_pc
);

  localparam int AW = n_reg + 1;

  logic [1:0]     state_q, state_d;
  dec_t           id_q;
  logic [31:0]    id_pc_q;
  logic [n_bit:0] hold_rs_q, hold_rt_q;

  logic           ex_valid_q, ex_wb_q, ex_mrd_q, ex_mwr_q, ex_br_q, ex_ill_q;
  logic [3:0]     ex_alu_q;
  logic [n_bit:0] ex_rs_q, ex_rt_q;
  logic [31:0]    ex_imm_q, ex_pc_q;
  logic [n_reg:0] ex_dest_q;

  dec_t           w_dec;
  logic [4:0]     w_rs, w_rt;
  logic           w_accept, w_out_free, w_hazard, w_ex_load, w_id_load;
  logic           w_rs_hit, w_rt_hit, w_load_ex, w_capture;
  logic [n_bit:0] w_rd1, w_rd2;

  mips_instr_decoder u_decoder (
    .instr_i (if_instr),
    .rs_o    (w_rs),
    .rt_o    (w_rt),
    .dec_o   (w_dec)
  );

  assign w_out_free = !ex_valid_q || ex_ready;
  assign w_accept   = if_valid && if_ready;

  // Pending loads live either in the EX register or in the ID holding slot.
  assign w_ex_load = ex_valid_q && ex_mrd_q;
  assign w_id_load = (state_q != S_IDLE) && id_q.mem_rd;
  assign w_rs_hit  = w_dec.reads_rs && (w_rs != 5'd0) &&
                     ((w_ex_load && ex_dest_q == AW'(w_rs)) || (w_id_load && id_q.dest == w_rs));
  assign w_rt_hit  = w_dec.reads_rt && (w_rt != 5'd0) &&
                     ((w_ex_load && ex_dest_q == AW'(w_rt)) || (w_id_load && id_q.dest == w_rt));
  assign w_hazard  = w_rs_hit || w_rt_hit;

  always_ff @(posedge clk) begin
    if (arst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:         if (w_accept) state_d = S_READ;
      S_READ, S_HOLD: begin
        if (w_out_free) state_d = w_accept ? S_READ : S_IDLE;
        else            state_d = S_HOLD;
      end
      default:        state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    if_ready = 1'b0;
    if (!arst && !flush && !w_hazard) begin
      case (state_q)
        S_IDLE:         if_ready = 1'b1;
        S_READ, S_HOLD: if_ready = w_out_free;
        default:        if_ready = 1'b0;
      endcase
    end
  end

  // Read requests ride the accept edge so RF data lands in the S_READ cycle.
  assign rf_r_1_en   = w_accept && w_dec.reads_rs;
  assign rf_r_2_en   = w_accept && w_dec.reads_rt;
  assign rf_addr_r_1 = rf_r_1_en ? AW'(w_rs) : '0;
  assign rf_addr_r_2 = rf_r_2_en ? AW'(w_rt) : '0;

  assign w_rd1     = id_q.reads_rs ? rf_r_data_1 : '0;
  assign w_rd2     = id_q.reads_rt ? rf_r_data_2 : '0;
  assign w_load_ex = ((state_q == S_READ) || (state_q == S_HOLD)) && w_out_free && !flush;
  assign w_capture = (state_q == S_READ) && !w_out_free && !flush;

  always_ff @(posedge clk) begin
    if (arst) begin
      id_q       <= '0;
      id_pc_q    <= '0;
      hold_rs_q  <= '0;
      hold_rt_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_alu_q   <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_imm_q   <= '0;
      ex_dest_q  <= '0;
      ex_wb_q    <= 1'b0;
      ex_mrd_q   <= 1'b0;
      ex_mwr_q   <= 1'b0;
      ex_br_q    <= 1'b0;
      ex_ill_q   <= 1'b0;
      ex_pc_q    <= '0;
    end else begin
      if (flush) begin
        ex_valid_q <= 1'b0;
      end else if (w_load_ex) begin
        ex_valid_q <= 1'b1;
        ex_alu_q   <= id_q.alu_op;
        ex_rs_q    <= (state_q == S_READ) ? w_rd1 : hold_rs_q;
        ex_rt_q    <= (state_q == S_READ) ? w_rd2 : hold_rt_q;
        ex_imm_q   <= id_q.imm;
        ex_dest_q  <= AW'(id_q.dest);
        ex_wb_q    <= id_q.wb_en;
        ex_mrd_q   <= id_q.mem_rd;
        ex_mwr_q   <= id_q.mem_wr;
        ex_br_q    <= id_q.branch;
        ex_ill_q   <= id_q.illegal;
        ex_pc_q    <= id_pc_q;
      end else if (ex_ready) begin
        ex_valid_q <= 1'b0;
      end
      if (w_accept) begin
        id_q    <= w_dec;
        id_pc_q <= if_pc;
      end
      if (w_capture) begin
        hold_rs_q <= w_rd1;
        hold_rt_q <= w_rd2;
      end
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_alu_op  = ex_alu_q;
  assign ex_rs_data = ex_rs_q;
  assign ex_rt_data = ex_rt_q;
  assign ex_imm     = ex_imm_q;
  assign ex_dest    = ex_dest_q;
  assign ex_wb_en   = ex_wb_q;
  assign ex_mem_rd  = ex_mrd_q;
  assign ex_mem_wr  = ex_mwr_q;
  assign ex_branch  = ex_br_q;
  assign ex_illegal = ex_ill_q;
  assign ex_pc      = ex_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mips_decode_stage                                                  |
// | Directed vector table plus stall / hazard / flush / reset sequences.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mips_decode_stage;

  logic        clk = 1'b0;
  logic        arst, if_valid, flush, ex_ready;
  logic [31:0] if_instr, if_pc;
  logic        if_ready, rf_r_1_en, rf_r_2_en;
  logic [5:0]  rf_addr_r_1, rf_addr_r_2;
  logic [31:0] rf_r_data_1, rf_r_data_2;
  logic        ex_valid, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_branch, ex_illegal;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
  logic [5:0]  ex_dest;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_decode_stage #(.n_bit(31), .n_reg(5)) dut (
    .clk(clk), .arst(arst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .rf_r_1_en(rf_r_1_en), .rf_addr_r_1(rf_addr_r_1),
    .rf_r_2_en(rf_r_2_en), .rf_addr_r_2(rf_addr_r_2),
    .rf_r_data_1(rf_r_data_1), .rf_r_data_2(rf_r_data_2),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_op(ex_alu_op), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_branch(ex_branch), .ex_illegal(ex_illegal), .ex_pc(ex_pc)
  );

  // Register-file model: registered read, contents derived from the address.
  function automatic logic [31:0] rfv(input logic [5:0] a);
    return 32'hC0DE_0000 + {26'd0, a};
  endfunction

  logic [31:0] rf_d1_q = '0, rf_d2_q = '0;
  logic        rf_zero2 = 1'b0;
  always @(posedge clk) begin
    if (rf_r_1_en) rf_d1_q <= rfv(rf_addr_r_1);
    if (rf_r_2_en) rf_d2_q <= rfv(rf_addr_r_2);
  end
  assign rf_r_data_1 = rf_d1_q;
  assign rf_r_data_2 = rf_zero2 ? 32'h0 : rf_d2_q;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [5:0]  dest;
    logic        wb, mrd, mwr, br, ill;
    logic        en1, en2;
    logic [5:0]  a1, a2;
  } vec_t;

  vec_t vt [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ex(input string t, input logic [3:0] alu, input logic [5:0] dest,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] pc);
    chk({t, ".valid"}, ex_valid, 1);
    chk({t, ".alu"}, ex_alu_op, alu);
    chk({t, ".dest"}, ex_dest, dest);
    chk({t, ".rs_data"}, ex_rs_data, rs);
    chk({t, ".rt_data"}, ex_rt_data, rt);
    chk({t, ".pc"}, ex_pc, pc);
  endtask

  initial begin
    //          instr          alu    imm            dest   wb    mrd   mwr   br    ill   en1   en2   a1     a2
    vt[0]  = '{32'h20080005, 4'd0,  32'h00000005, 6'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd0};
    vt[1]  = '{32'h3C01ABCD, 4'd5,  32'hABCD0000, 6'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0};
    vt[2]  = '{32'hFC000000, 4'd15, 32'h00000000, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  6'd0};
    vt[3]  = '{32'h316A8001, 4'd2,  32'h00008001, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd11, 6'd0};
    vt[4]  = '{32'h2128FFFF, 4'd0,  32'hFFFFFFFF, 6'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd9,  6'd0};
    vt[5]  = '{32'h8E090004, 4'd0,  32'h00000004, 6'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd16, 6'd0};
    vt[6]  = '{32'hAFA9FFF8, 4'd0,  32'hFFFFFFF8, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd29, 6'd9};
    vt[7]  = '{32'h11090010, 4'd1,  32'h00000010, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd8,  6'd9};
    vt[8]  = '{32'h01095020, 4'd0,  32'h00000000, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd8,  6'd9};
    vt[9]  = '{32'h0109582A, 4'd4,  32'h00000000, 6'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd8,  6'd9};
    vt[10] = '{32'h01090020, 4'd0,  32'h00000000, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd8,  6'd9};
    vt[11] = '{32'h0109503F, 4'd15, 32'h00000000, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  6'd0};
    vt[12] = '{32'h3408FFFF, 4'd3,  32'h0000FFFF, 6'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd0};

    arst = 1'b1; if_valid = 1'b1; if_instr = 32'h20080005; if_pc = 32'h0; flush = 1'b0; ex_ready = 1'b1;

    // Reset: nothing accepted or requested while arst is high.
    tick(); tick(); mid();
    chk("rst.if_ready", if_ready, 0);
    chk("rst.rf_en1", rf_r_1_en, 0);
    chk("rst.ex_valid", ex_valid, 0);
    tick(); arst = 1'b0; if_valid = 1'b0; mid();
    chk("rst.ex_alu", ex_alu_op, 0);
    chk("rst.ex_imm", ex_imm, 0);
    chk("rst.ex_dest", ex_dest, 0);
    chk("rst.ex_pc", ex_pc, 0);
    chk("rst.ex_illegal", ex_illegal, 0);

    // Single-instruction vectors, accept-to-ex_valid = 2 edges.
    for (int i = 0; i < 13; i++) begin
      tick(); if_valid = 1'b1; if_instr = vt[i].instr; if_pc = 32'h0040_0000 + 32'(i * 4);
      mid();
      chk($sformatf("v%0d.if_ready", i), if_ready, 1);
      chk($sformatf("v%0d.en1", i), rf_r_1_en, vt[i].en1);
      chk($sformatf("v%0d.addr1", i), rf_addr_r_1, vt[i].a1);
      chk($sformatf("v%0d.en2", i), rf_r_2_en, vt[i].en2);
      chk($sformatf("v%0d.addr2", i), rf_addr_r_2, vt[i].a2);
      tick(); if_valid = 1'b0;
      tick(); mid();
      chk_ex($sformatf("v%0d", i), vt[i].alu, vt[i].dest,
             vt[i].en1 ? rfv(vt[i].a1) : 32'h0, vt[i].en2 ? rfv(vt[i].a2) : 32'h0,
             32'h0040_0000 + 32'(i * 4));
      chk($sformatf("v%0d.imm", i), ex_imm, vt[i].imm);
      chk($sformatf("v%0d.wb", i), ex_wb_en, vt[i].wb);
      chk($sformatf("v%0d.mem_rd", i), ex_mem_rd, vt[i].mrd);
      chk($sformatf("v%0d.mem_wr", i), ex_mem_wr, vt[i].mwr);
      chk($sformatf("v%0d.branch", i), ex_branch, vt[i].br);
      chk($sformatf("v%0d.illegal", i), ex_illegal, vt[i].ill);
      tick(); mid();
      chk($sformatf("v%0d.drain", i), ex_valid, 0);
    end

    // Back-to-back add / sub / or at full rate.
    begin
      logic [31:0] ins [3];
      logic [3:0]  alu [3];
      logic [5:0]  rd [3], rs [3], rt [3];
      ins = '{32'h01095020, 32'h018D5822, 32'h01CF6025};
      alu = '{4'd0, 4'd1, 4'd3};
      rd  = '{6'd10, 6'd11, 6'd12};
      rs  = '{6'd8, 6'd12, 6'd14};
      rt  = '{6'd9, 6'd13, 6'd15};
      for (int k = 0; k < 5; k++) begin
        tick();
        if (k < 3) begin
          if_valid = 1'b1; if_instr = ins[k]; if_pc = 32'h0000_1000 + 32'(k * 4);
        end else begin
          if_valid = 1'b0;
        end
        mid();
        if (k < 3) chk($sformatf("b2b%0d.if_ready", k), if_ready, 1);
        if (k >= 2) chk_ex($sformatf("b2b%0d", k - 2), alu[k-2], rd[k-2], rfv(rs[k-2]), rfv(rt[k-2]),
                           32'h0000_1000 + 32'((k - 2) * 4));
      end
      tick(); mid();
      chk("b2b.drain", ex_valid, 0);
    end

    // Back-pressure: second instruction parks in S_HOLD, RF data then changes.
    tick(); ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h01095020; if_pc = 32'h0000_2000;
    mid(); chk("hold.acc0", if_ready, 1);
    tick(); if_instr = 32'h018D5822; if_pc = 32'h0000_2004;
    mid(); chk("hold.acc1", if_ready, 1);
    tick(); if_valid = 1'b0;
    mid(); chk("hold.c2.if_ready", if_ready, 0); chk_ex("hold.c2", 4'd0, 6'd10, rfv(8), rfv(9), 32'h2000);
    tick(); rf_zero2 = 1'b1;
    mid(); chk("hold.c3.if_ready", if_ready, 0); chk_ex("hold.c3", 4'd0, 6'd10, rfv(8), rfv(9), 32'h2000);
    tick();
    mid(); chk("hold.c4.if_ready", if_ready, 0); chk_ex("hold.c4", 4'd0, 6'd10, rfv(8), rfv(9), 32'h2000);
    tick(); ex_ready = 1'b1;
    mid(); chk("hold.c5.if_ready", if_ready, 1); chk_ex("hold.c5", 4'd0, 6'd10, rfv(8), rfv(9), 32'h2000);
    tick();
    mid(); chk_ex("hold.c6", 4'd1, 6'd11, rfv(12), rfv(13), 32'h2004);
    tick(); rf_zero2 = 1'b0;
    mid(); chk("hold.drain", ex_valid, 0);

    // Load-use: add $t2,$t1,$t1 waits until the lw has left the EX register.
    tick(); if_valid = 1'b1; if_instr = 32'h8E090004; if_pc = 32'h0000_3000;
    mid(); chk("lu.lw_ready", if_ready, 1);
    tick(); if_instr = 32'h01295020; if_pc = 32'h0000_3004;
    mid(); chk("lu.stall_id", if_ready, 0);
    tick();
    mid(); chk("lu.stall_ex", if_ready, 0); chk("lu.lw_in_ex", ex_mem_rd, 1); chk("lu.lw_valid", ex_valid, 1);
    tick();
    mid(); chk("lu.release", if_ready, 1); chk("lu.bubble", ex_valid, 0);
    tick(); if_valid = 1'b0;
    mid(); chk("lu.bubble2", ex_valid, 0);
    tick();
    mid(); chk_ex("lu.add", 4'd0, 6'd10, rfv(9), rfv(9), 32'h3004);
    tick();

    // Flush while a bundle waits in EX and another sits in S_HOLD.
    tick(); ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h01095020; if_pc = 32'h0000_4000;
    tick(); if_instr = 32'h018D5822; if_pc = 32'h0000_4004;
    tick(); if_valid = 1'b0;
    tick(); flush = 1'b1; if_valid = 1'b1; if_instr = 32'h20080005;
    mid(); chk("fl.if_ready", if_ready, 0); chk("fl.rf_en1", rf_r_1_en, 0); chk("fl.pre_valid", ex_valid, 1);
    tick(); flush = 1'b0; if_valid = 1'b0;
    mid(); chk("fl.ex_valid", ex_valid, 0);
    tick(); ex_ready = 1'b1;
    mid(); chk("fl.no_stale1", ex_valid, 0);
    tick();
    mid(); chk("fl.no_stale2", ex_valid, 0); chk("fl.idle_ready", if_ready, 1);

    // Reset in the S_READ cycle must drop the instruction.
    tick(); if_valid = 1'b1; if_instr = 32'h20080005; if_pc = 32'h0000_5000;
    tick(); if_valid = 1'b0; arst = 1'b1;
    mid(); chk("mrst.if_ready", if_ready, 0);
    tick(); arst = 1'b0;
    mid(); chk("mrst.ex_valid", ex_valid, 0);
    tick();
    mid(); chk("mrst.ex_valid2", ex_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
